// File: rtl/fft_pkg.sv
// Shared types and index mapping for the 64-point DFT result path.
// The 8x8 array type is common to the DFT core and its output streamer.
package fft_pkg;

   localparam int NPT   = 64;
   localparam int NROW  = 8;
   localparam int W_DEF = 16;

   typedef logic [W_DEF-1:0] sample_t;
   typedef sample_t [0:NROW-1][0:NROW-1] fft_arr_t;

   typedef struct packed {
      logic [2:0] row;
      logic [2:0] col;
   } rc_t;

   typedef enum logic {IDLE, STREAM} state_t;

   // Row-major: bin = 8*row + col. Column-major: bin = row + 8*col.
   function automatic rc_t bin_map(input logic [5:0] counter, input logic col_major);
      rc_t rc;
      if (col_major) begin
         rc.row = 3'(counter % 6'(NROW));
         rc.col = 3'(counter / 6'(NROW));
      end else begin
         rc.row = 3'(counter / 6'(NROW));
         rc.col = 3'(counter % 6'(NROW));
      end
      return rc;
   endfunction

endpackage

// File: rtl/fft64_frame_buffer.sv
// 64-entry real/imag frame store: full 8x8 parallel write, one indexed read.
// Read is combinational from the stored registers; write takes effect next edge.
module fft64_frame_buffer
   import fft_pkg::*;
#(
   parameter int W = 16
) (
   input  logic                              clk,
   input  logic                              we_i,
   input  logic [0:NROW-1][0:NROW-1][W-1:0]  real_i,
   input  logic [0:NROW-1][0:NROW-1][W-1:0]  imag_i,
   input  logic [2:0]                        rd_row_i,
   input  logic [2:0]                        rd_col_i,
   output logic [W-1:0]                      real_o,
   output logic [W-1:0]                      imag_o
);

   logic [0:NROW-1][0:NROW-1][W-1:0] real_q;
   logic [0:NROW-1][0:NROW-1][W-1:0] imag_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         real_q <= real_i;
         imag_q <= imag_i;
      end
   end

   assign real_o = real_q[rd_row_i][rd_col_i];
   assign imag_o = imag_q[rd_row_i][rd_col_i];

endmodule

// File: rtl/fft64_bin_streamer.sv
// Captures a DFT frame on frame_done and streams 64 bins over valid/ready;
// out_valid rises the cycle after capture, holds under stall, frames arriving mid-stream are dropped.
module fft64_bin_streamer
   import fft_pkg::*;
#(
   parameter int W         = 16,
   parameter bit COL_MAJOR = 1'b0
) (
   input  logic                     clk,
   input  logic                     sreset,
   input  logic                     frame_done,
   input  logic [0:7][0:7][W-1:0]   realfft_in,
   input  logic [0:7][0:7][W-1:0]   imagfft_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [W-1:0]             out_real,
   output logic [W-1:0]             out_imag,
   output logic [5:0]               out_index,
   output logic                     out_last,
   output logic                     busy,
   output logic                     overrun,
   input  logic                     clear_overrun
);

   localparam logic [5:0] LAST_BIN = 6'(NPT - 1);

   state_t     state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic       ovr_q, ovr_d;
   logic       capture;
   logic       drop;
   logic       stream;
   rc_t        rc;
   logic [W-1:0] rd_real;
   logic [W-1:0] rd_imag;

   assign rc = bin_map(cnt_q, COL_MAJOR);

   fft64_frame_buffer #(.W(W)) u_buf (
      .clk      (clk),
      .we_i     (capture),
      .real_i   (realfft_in),
      .imag_i   (imagfft_in),
      .rd_row_i (rc.row),
      .rd_col_i (rc.col),
      .real_o   (rd_real),
      .imag_o   (rd_imag)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      drop    = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_done) begin
               capture = 1'b1;
               cnt_d   = '0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (out_ready) begin
               if (cnt_q == LAST_BIN) begin
                  cnt_d = '0;
                  // A frame landing on the final beat is taken without a bubble.
                  if (frame_done) capture = 1'b1;
                  else            state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
            drop = frame_done && !capture;
         end
         default: state_d = IDLE;
      endcase

      ovr_d = ovr_q;
      if (drop)               ovr_d = 1'b1;
      else if (clear_overrun) ovr_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (sreset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
      end
   end

   // Buffer contents are undefined outside a frame, so data is masked when idle.
   assign stream    = (state_q == STREAM);
   assign out_valid = stream;
   assign busy      = stream;
   assign out_real  = stream ? rd_real : '0;
   assign out_imag  = stream ? rd_imag : '0;
   assign out_index = cnt_q;
   assign out_last  = stream && (cnt_q == LAST_BIN);
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_fft64_bin_streamer.sv
// Directed bench: row/col-major ordering, stalls, overrun, back-to-back and reset mid-stream.
module tb_fft64_bin_streamer;

   logic                    clk = 1'b0;
   logic                    sreset = 1'b1;
   logic                    frame_done = 1'b0;
   logic [0:7][0:7][15:0]   rin;
   logic [0:7][0:7][15:0]   iin;
   logic                    out_ready = 1'b1;
   logic                    clear_overrun = 1'b0;

   logic        v0, l0, b0, o0, v1, l1, b1, o1;
   logic [15:0] r0, i0, r1, i1;
   logic [5:0]  x0, x1;

   int checks = 0;
   int errs   = 0;

   always #5 clk = ~clk;

   fft64_bin_streamer #(.W(16), .COL_MAJOR(1'b0)) dut0 (
      .clk(clk), .sreset(sreset), .frame_done(frame_done),
      .realfft_in(rin), .imagfft_in(iin),
      .out_valid(v0), .out_ready(out_ready), .out_real(r0), .out_imag(i0),
      .out_index(x0), .out_last(l0), .busy(b0), .overrun(o0),
      .clear_overrun(clear_overrun)
   );

   fft64_bin_streamer #(.W(16), .COL_MAJOR(1'b1)) dut1 (
      .clk(clk), .sreset(sreset), .frame_done(frame_done),
      .realfft_in(rin), .imagfft_in(iin),
      .out_valid(v1), .out_ready(out_ready), .out_real(r1), .out_imag(i1),
      .out_index(x1), .out_last(l1), .busy(b1), .overrun(o1),
      .clear_overrun(clear_overrun)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rm_real(input int n);
      return 16'(16 * (n >> 3) + (n & 7));
   endfunction

   function automatic logic [15:0] cm_real(input int n);
      return 16'(16 * (n & 7) + (n >> 3));
   endfunction

   task automatic set_frame_idx();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            rin[r][c] = 16'(16 * r + c);
            iin[r][c] = 16'(-(16 * r + c));
         end
   endtask

   task automatic set_frame_const(input logic [15:0] re, input logic [15:0] im);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            rin[r][c] = re;
            iin[r][c] = im;
         end
   endtask

   task automatic start_frame();
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
   endtask

   task automatic test_reset();
      sreset = 1'b1;
      step();
      step();
      sreset = 1'b0;
      checks++;
      if ({v0, r0, i0, x0, l0, b0, o0} !== '0) begin
         errs++;
         $display("FAIL reset_state: got v=%b re=%h im=%h idx=%0d last=%b busy=%b ovr=%b, want all 0",
                  v0, r0, i0, x0, l0, b0, o0);
      end
   endtask

   task automatic test_row_major();
      set_frame_idx();
      out_ready = 1'b1;
      start_frame();
      for (int n = 0; n < 64; n++) begin
         checks++;
         if (v0 !== 1'b1 || x0 !== 6'(n) || r0 !== rm_real(n) || i0 !== 16'(-int'(rm_real(n)))
             || l0 !== (n == 63) || b0 !== 1'b1) begin
            errs++;
            $display("FAIL row_major beat %0d: got v=%b idx=%0d re=%h im=%h last=%b busy=%b, want v=1 idx=%0d re=%h im=%h last=%b",
                     n, v0, x0, r0, i0, l0, b0, n, rm_real(n), 16'(-int'(rm_real(n))), n == 63);
         end
         checks++;
         if (v1 !== 1'b1 || x1 !== 6'(n) || r1 !== cm_real(n) || i1 !== 16'(-int'(cm_real(n)))) begin
            errs++;
            $display("FAIL col_major beat %0d: got v=%b idx=%0d re=%h im=%h, want re=%h im=%h",
                     n, v1, x1, r1, i1, cm_real(n), 16'(-int'(cm_real(n))));
         end
         if (n == 9) begin
            checks++;
            if (r0 !== 16'h0011 || i0 !== 16'hFFEF) begin
               errs++;
               $display("FAIL beat9_value: got re=%h im=%h, want 0011 FFEF", r0, i0);
            end
         end
         if (n == 1 || n == 8) begin
            checks++;
            if (r1 !== ((n == 1) ? 16'h0010 : 16'h0001)) begin
               errs++;
               $display("FAIL col_major_beat%0d: got re=%h", n, r1);
            end
         end
         step();
      end
      checks++;
      if (v0 !== 1'b0 || b0 !== 1'b0 || l0 !== 1'b0 || x0 !== 6'd0) begin
         errs++;
         $display("FAIL end_of_frame: got v=%b busy=%b last=%b idx=%0d, want 0 0 0 0", v0, b0, l0, x0);
      end
   endtask

   task automatic test_stall();
      int exp_idx = 0;
      logic pv = 1'b0, pr = 1'b0;
      logic [15:0] pre = '0, pim = '0;
      logic [5:0]  pidx = '0;
      set_frame_idx();
      start_frame();
      for (int cyc = 0; cyc < 400 && exp_idx < 64; cyc++) begin
         checks++;
         if (v0 !== 1'b1 || x0 !== 6'(exp_idx) || r0 !== rm_real(exp_idx)) begin
            errs++;
            $display("FAIL stall_order cyc %0d: got v=%b idx=%0d re=%h, want v=1 idx=%0d re=%h",
                     cyc, v0, x0, r0, exp_idx, rm_real(exp_idx));
         end
         if (pv && !pr) begin
            checks++;
            if (r0 !== pre || i0 !== pim || x0 !== pidx) begin
               errs++;
               $display("FAIL stall_hold cyc %0d: got idx=%0d re=%h im=%h, want idx=%0d re=%h im=%h",
                        cyc, x0, r0, i0, pidx, pre, pim);
            end
         end
         pv = v0; pre = r0; pim = i0; pidx = x0;
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         pr = out_ready;
         if (v0 && out_ready) exp_idx++;
         step();
      end
      out_ready = 1'b1;
      checks++;
      if (exp_idx != 64 || v0 !== 1'b0) begin
         errs++;
         $display("FAIL stall_complete: got beats=%0d v=%b, want 64 beats then v=0", exp_idx, v0);
      end
   endtask

   task automatic test_overrun();
      set_frame_idx();
      out_ready = 1'b1;
      start_frame();
      for (int n = 0; n < 64; n++) begin
         checks++;
         if (v0 !== 1'b1 || x0 !== 6'(n) || r0 !== rm_real(n)) begin
            errs++;
            $display("FAIL overrun_data beat %0d: got v=%b idx=%0d re=%h, want idx=%0d re=%h",
                     n, v0, x0, r0, n, rm_real(n));
         end
         if (n == 21 || n == 41 || n == 42) begin
            checks++;
            if (o0 !== (n != 42)) begin
               errs++;
               $display("FAIL overrun_flag beat %0d: got %b, want %b", n, o0, n != 42);
            end
         end
         frame_done    = (n == 20) || (n == 40);
         clear_overrun = (n == 40) || (n == 41);
         if (n == 20) set_frame_const(16'h7FFF, 16'h7FFF);
         step();
      end
      frame_done = 1'b0;
      clear_overrun = 1'b0;
      checks++;
      if (v0 !== 1'b0 || o0 !== 1'b0) begin
         errs++;
         $display("FAIL overrun_end: got v=%b ovr=%b, want 0 0", v0, o0);
      end
   endtask

   task automatic test_back_to_back();
      set_frame_idx();
      out_ready = 1'b1;
      start_frame();
      for (int n = 0; n < 64; n++) begin
         if (n == 63) begin
            set_frame_const(16'h7FFF, 16'h8001);
            frame_done = 1'b1;
         end
         step();
      end
      frame_done = 1'b0;
      checks++;
      if (v0 !== 1'b1 || x0 !== 6'd0 || r0 !== 16'h7FFF || i0 !== 16'h8001 || o0 !== 1'b0) begin
         errs++;
         $display("FAIL back_to_back: got v=%b idx=%0d re=%h im=%h ovr=%b, want 1 0 7fff 8001 0",
                  v0, x0, r0, i0, o0);
      end
      for (int n = 0; n < 64; n++) step();
      checks++;
      if (v0 !== 1'b0 || b0 !== 1'b0) begin
         errs++;
         $display("FAIL back_to_back_end: got v=%b busy=%b, want 0 0", v0, b0);
      end
   endtask

   task automatic test_reset_mid();
      set_frame_idx();
      out_ready = 1'b1;
      start_frame();
      for (int n = 0; n < 31; n++) begin
         frame_done = (n == 10);
         sreset     = (n == 30);
         step();
      end
      frame_done = 1'b0;
      sreset = 1'b0;
      checks++;
      if (v0 !== 1'b0 || b0 !== 1'b0 || x0 !== 6'd0 || o0 !== 1'b0) begin
         errs++;
         $display("FAIL reset_mid: got v=%b busy=%b idx=%0d ovr=%b, want 0 0 0 0", v0, b0, x0, o0);
      end
      step();
      checks++;
      if (v0 !== 1'b0) begin
         errs++;
         $display("FAIL reset_mid_quiet: got v=%b, want 0", v0);
      end
      start_frame();
      for (int n = 0; n < 64; n++) begin
         checks++;
         if (v0 !== 1'b1 || x0 !== 6'(n) || r0 !== rm_real(n) || l0 !== (n == 63)) begin
            errs++;
            $display("FAIL fresh_frame beat %0d: got v=%b idx=%0d re=%h last=%b, want idx=%0d re=%h",
                     n, v0, x0, r0, l0, n, rm_real(n));
         end
         step();
      end
   endtask

   initial begin
      set_frame_const(16'h0, 16'h0);
      test_reset();
      test_row_major();
      test_stall();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
